loopback_bist: RTL and testbench

Synthesizable built-in self-test for the BPSK link. It generates NUM_PACKETS payload packets, serializes them bit by bit into the signal_modulator on its bit-request strobe, and checks the byte stream returned by the reciever against the same sequence regenerated locally. It reports pass/fail, error count and timeout, and replaces the fixed-packet, check-by-eye bench arrangement with a self-checking, multi-packet, parametrised one.

---
 rtl/loopback_bist.sv | 177 +++++++++++++++++
 tb/tb_loopback_bist.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/loopback_bist.sv
// Loopback BIST: an LFSR payload is serialised into the modulator and received bytes are checked against a local copy.
// Optional macro BIST_FIRST_ERR_EN adds first-mismatch capture outputs (first_err_*).
module loopback_bist #(
  parameter int         PAYLOAD_BYTES  = 23,
  parameter int         NUM_PACKETS    = 4,
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         ERR_WIDTH      = 16,
  localparam int        TOTAL_BYTES    = PAYLOAD_BYTES * NUM_PACKETS,
  localparam int        IDX_W          = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 ser_next,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  output logic                 ser_signal,
  output logic                 mod_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [ERR_WIDTH-1:0] error_count,
  output logic [1:0]           state_dbg
`ifdef BIST_FIRST_ERR_EN
  ,
  output logic                 first_err_valid,
  output logic [IDX_W-1:0]     first_err_index,
  output logic [7:0]           first_err_expected,
  output logic [7:0]           first_err_received
`endif
);

  localparam int BYTE_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int PKT_W  = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
  localparam int CNT_W  = $clog2(TOTAL_BYTES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          tx_lfsr, rx_lfsr;
  logic [2:0]          bit_idx;
  logic [BYTE_W-1:0]   byte_idx;
  logic [PKT_W-1:0]    pkt_idx;
  logic [CNT_W-1:0]    rx_count;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [ERR_WIDTH-1:0] err_next;

  logic run, tx_fire, rx_fire, mismatch, rx_last, idle_hit;
  logic byte_wrap, pkt_wrap, tx_last;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // ser_next and rx_valid are single-cycle strobes with no backpressure: each
  // high cycle in RUN is exactly one transfer, both may coincide, none is ever stalled.
  assign run       = (state_q == S_RUN);
  assign tx_fire   = run && mod_enable && ser_next;
  assign rx_fire   = run && rx_valid;
  assign mismatch  = rx_fire && (rx_byte != rx_lfsr);
  assign err_next  = (mismatch && (error_count != {ERR_WIDTH{1'b1}}))
                     ? error_count + ERR_WIDTH'(1) : error_count;
  assign rx_last   = rx_fire && (rx_count == CNT_W'(TOTAL_BYTES - 1));
  assign idle_hit  = run && !ser_next && !rx_valid && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign byte_wrap = (byte_idx == BYTE_W'(PAYLOAD_BYTES - 1));
  assign pkt_wrap  = (pkt_idx == PKT_W'(NUM_PACKETS - 1));
  assign tx_last   = tx_fire && (bit_idx == 3'd7) && byte_wrap && pkt_wrap;

  // ~bit_idx selects bit 7-bit_idx, so the byte leaves MSB first.
  assign ser_signal = mod_enable ? tx_lfsr[~bit_idx] : 1'b0;
  assign state_dbg  = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN:          if (rx_last || idle_hit) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_lfsr     <= LFSR_SEED;
      rx_lfsr     <= LFSR_SEED;
      bit_idx     <= '0;
      byte_idx    <= '0;
      pkt_idx     <= '0;
      rx_count    <= '0;
      idle_cnt    <= '0;
      error_count <= '0;
      mod_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
    end else if (start && !run) begin
      tx_lfsr     <= LFSR_SEED;
      rx_lfsr     <= LFSR_SEED;
      bit_idx     <= '0;
      byte_idx    <= '0;
      pkt_idx     <= '0;
      rx_count    <= '0;
      idle_cnt    <= '0;
      error_count <= '0;
      mod_enable  <= 1'b1;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
    end else if (run) begin
      if (tx_fire) begin
        bit_idx <= bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
          tx_lfsr  <= lfsr_step(tx_lfsr);
          byte_idx <= byte_wrap ? '0 : byte_idx + BYTE_W'(1);
          if (byte_wrap) pkt_idx <= pkt_wrap ? '0 : pkt_idx + PKT_W'(1);
        end
        if (tx_last) mod_enable <= 1'b0;
      end
      if (rx_fire) begin
        error_count <= err_next;
        rx_lfsr     <= lfsr_step(rx_lfsr);
        rx_count    <= rx_count + CNT_W'(1);
      end
      idle_cnt <= (ser_next || rx_valid) ? '0 : idle_cnt + IDLE_W'(1);
      // pass reflects the error count including the final byte's compare.
      if (rx_last) begin
        done       <= 1'b1;
        busy       <= 1'b0;
        pass       <= (err_next == '0);
        mod_enable <= 1'b0;
      end
      if (idle_hit) begin
        timeout    <= 1'b1;
        done       <= 1'b1;
        pass       <= 1'b0;
        busy       <= 1'b0;
        mod_enable <= 1'b0;
      end
    end
  end

`ifdef BIST_FIRST_ERR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_err_valid    <= 1'b0;
      first_err_index    <= '0;
      first_err_expected <= '0;
      first_err_received <= '0;
    end else if (start && !run) begin
      first_err_valid    <= 1'b0;
      first_err_index    <= '0;
      first_err_expected <= '0;
      first_err_received <= '0;
    end else if (mismatch && !first_err_valid) begin
      first_err_valid    <= 1'b1;
      first_err_index    <= IDX_W'(rx_count);
      first_err_expected <= rx_lfsr;
      first_err_received <= rx_byte;
    end
  end
`endif

endmodule

// File: tb/tb_loopback_bist.sv
// Bench for loopback_bist: randomized loopback runs against a payload model, with a bit/result scoreboard.
module tb_loopback_bist;
  localparam int PB    = 23;
  localparam int NP    = 4;
  localparam int TOTAL = PB * NP;
  localparam int TMO   = 200;

  logic       clock = 1'b0;
  logic       reset, start, ser_next, rx_valid;
  logic [7:0] rx_byte;
  logic       ser_signal, mod_enable, busy, done, pass, timeout;
  logic [15:0] error_count;
  logic [1:0] state_dbg;
  logic       ser_signal2, mod_enable2, busy2, done2, pass2, timeout2;
  logic [1:0] error_count2, state_dbg2;
`ifdef BIST_FIRST_ERR_EN
  logic       fe_valid, fe_valid2;
  logic [6:0] fe_index, fe_index2;
  logic [7:0] fe_exp, fe_exp2, fe_rcv, fe_rcv2;
`endif

  loopback_bist #(.PAYLOAD_BYTES(PB), .NUM_PACKETS(NP), .LFSR_SEED(8'hA5),
                  .TIMEOUT_CYCLES(TMO), .ERR_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .ser_next(ser_next),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .ser_signal(ser_signal),
    .mod_enable(mod_enable), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .error_count(error_count), .state_dbg(state_dbg)
`ifdef BIST_FIRST_ERR_EN
    , .first_err_valid(fe_valid), .first_err_index(fe_index),
    .first_err_expected(fe_exp), .first_err_received(fe_rcv)
`endif
  );

  loopback_bist #(.PAYLOAD_BYTES(PB), .NUM_PACKETS(NP), .LFSR_SEED(8'hA5),
                  .TIMEOUT_CYCLES(TMO), .ERR_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .ser_next(ser_next),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .ser_signal(ser_signal2),
    .mod_enable(mod_enable2), .busy(busy2), .done(done2), .pass(pass2),
    .timeout(timeout2), .error_count(error_count2), .state_dbg(state_dbg2)
`ifdef BIST_FIRST_ERR_EN
    , .first_err_valid(fe_valid2), .first_err_index(fe_index2),
    .first_err_expected(fe_exp2), .first_err_received(fe_rcv2)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        tmo;
    logic        ps;
    logic [15:0] err;
    logic [1:0]  err2;
    logic        fv;
    logic [6:0]  fi;
    logic [7:0]  fe;
    logic [7:0]  fr;
  } res_t;

  logic       exp_bit_q[$];
  res_t       exp_res_q[$];
  logic [7:0] payload [TOTAL];
  int         n_pass = 0;
  int         n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic fail_event(input string name, input int info);
    n_total++;
    $display("FAIL %s: unexpected event, info=%0d (t=%0t)", name, info, $time);
  endtask

  // Payload rule: double the byte mod 256 and add the parity of taps 8,6,5,4.
  function automatic logic [7:0] next_payload(input logic [7:0] x);
    int fb;
    fb = int'(x[7]) + int'(x[5]) + int'(x[4]) + int'(x[3]);
    return 8'((int'(x) * 2 + fb % 2) % 256);
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    done, 0);
    check({tag, "_pass"},    pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_mod_en"},  mod_enable, 0);
    check({tag, "_ser"},     ser_signal, 0);
    check({tag, "_errcnt"},  error_count, 0);
    check({tag, "_state"},   state_dbg, 0);
  endtask

  // Monitor: consumes expected TX bits on each honoured strobe and results on each done rise.
  initial begin : monitor
    logic done_q;
    logic b;
    res_t r;
    done_q = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) done_q = 1'b0;
      else begin
        if (ser_next && mod_enable) begin
          if (exp_bit_q.size() == 0) fail_event("tx_extra_bit", 0);
          else begin
            b = exp_bit_q.pop_front();
            check("tx_bit", ser_signal, b);
          end
        end
        if (done && !done_q) begin
          if (exp_res_q.size() == 0) fail_event("unexpected_done", 0);
          else begin
            r = exp_res_q.pop_front();
            check("res_timeout", timeout, r.tmo);
            check("res_pass", pass, r.ps);
            check("res_errcnt", error_count, r.err);
            check("res_busy", busy, 0);
            check("res_mod_en", mod_enable, 0);
            check("sat_done", done2, 1);
            check("sat_errcnt", error_count2, r.err2);
            check("sat_pass", pass2, r.ps);
`ifdef BIST_FIRST_ERR_EN
            check("fe_valid", fe_valid, r.fv);
            if (r.fv) begin
              check("fe_index", fe_index, r.fi);
              check("fe_expected", fe_exp, r.fe);
              check("fe_received", fe_rcv, r.fr);
            end
`endif
          end
        end
        done_q = done;
      end
    end
  end

  // cmode: 0 clean, 1 byte 10 bit 0 flipped, 2 every byte corrupted. gap 0 = random 1..4.
  task automatic run_test(input int gap, input int cmode, input bit rx_en,
                          input int abort_byte, input bit start_mid);
    logic [7:0] mask [TOTAL];
    int   chan_q[$];
    int   bits_sent, extra, rx_sent, gap_cnt, cyc, nerr, idx;
    bit   fe_set, last_now;
    res_t r;
    nerr = 0; fe_set = 0; r = '0;
    for (int i = 0; i < TOTAL; i++) begin
      mask[i] = (cmode == 1 && i == 10) ? 8'h01 :
                (cmode == 2) ? 8'($urandom_range(1, 255)) : 8'h00;
      if (mask[i] != 8'h00 && rx_en) begin
        nerr++;
        if (!fe_set) begin
          fe_set = 1; r.fi = 7'(i); r.fe = payload[i]; r.fr = payload[i] ^ mask[i];
        end
      end
      for (int b = 7; b >= 0; b--) exp_bit_q.push_back(payload[i][b]);
    end
    r.fv   = fe_set;
    r.tmo  = !rx_en;
    r.ps   = rx_en && (nerr == 0);
    r.err  = 16'(nerr);
    r.err2 = (nerr > 3) ? 2'd3 : 2'(nerr);
    if (abort_byte < 0) exp_res_q.push_back(r);

    start = 1'b1;
    next_cycle();
    start = 1'b0;
    check("run_busy", busy, 1);
    bits_sent = 0; extra = 0; rx_sent = 0; gap_cnt = 0; cyc = 0;
    while ((bits_sent < TOTAL * 8 || extra < 3 || (rx_en && rx_sent < TOTAL)) && cyc < 20000) begin
      if (abort_byte >= 0 && bits_sent == abort_byte * 8 + 3) begin
        ser_next = 0; rx_valid = 0; reset = 1; #1;
        check_idle_outputs("abort_reset");
        next_cycle(); next_cycle();
        check_idle_outputs("abort_hold");
        reset = 0;
        exp_bit_q.delete();
        next_cycle();
        check("abort_state", state_dbg, 0);
        return;
      end
      ser_next = 0; rx_valid = 0; last_now = 0;
      rx_byte = 8'($urandom_range(0, 255));
      start = (start_mid && cyc == 300);
      if (gap_cnt == 0) begin
        gap_cnt = (gap > 0) ? gap - 1 : $urandom_range(0, 3);
        if (bits_sent < TOTAL * 8) begin
          ser_next = 1; bits_sent++;
          if (bits_sent % 8 == 0) chan_q.push_back(bits_sent / 8 - 1);
          last_now = (bits_sent == TOTAL * 8);
        end else if (extra < 3) begin
          ser_next = 1; extra++;
        end
      end else gap_cnt--;
      if (rx_en && chan_q.size() > 0 && (ser_next || $urandom_range(0, 1) == 1)) begin
        idx = chan_q.pop_front();
        rx_byte = payload[idx] ^ mask[idx];
        rx_valid = 1; rx_sent++;
      end
      next_cycle();
      cyc++;
      if (last_now) begin
        check("tx_end_mod_en", mod_enable, 0);
        check("tx_end_ser", ser_signal, 0);
      end
    end
    start = 0; ser_next = 0; rx_valid = 0;
    cyc = 0;
    while (!done && cyc < 400) begin
      next_cycle();
      cyc++;
    end
    if (!done) begin
      fail_event("done_wait_expired", cyc);
      exp_res_q.delete();
    end
    repeat (3) next_cycle();
    check("bits_consumed", exp_bit_q.size(), 0);
    check("results_consumed", exp_res_q.size(), 0);
    exp_bit_q.delete();
  endtask

  initial begin
    reset = 1; start = 0; ser_next = 0; rx_valid = 0; rx_byte = 8'h00;
    payload[0] = 8'hA5;
    for (int i = 1; i < TOTAL; i++) payload[i] = next_payload(payload[i-1]);
    repeat (3) next_cycle();
    check_idle_outputs("reset");
    reset = 0;
    next_cycle();
    check_idle_outputs("post_reset");

    run_test(16, 0, 1, -1, 0);  // clean, ser_next every 16 cycles
    run_test(0, 1, 1, -1, 0);   // byte 10 corrupted
    run_test(0, 2, 1, -1, 0);   // every byte corrupted, 2-bit counter saturates
    run_test(0, 0, 0, -1, 0);   // no receive -> timeout
    run_test(0, 0, 1, 50, 0);   // reset in packet 2
    run_test(0, 0, 1, -1, 0);   // rerun from seed after abort
    run_test(0, 0, 1, -1, 1);   // start pulsed mid-run

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
